// File: rtl/fp_align_pkg.sv
// rtl/fp_align_pkg.sv - shared types and helpers for the mantissa alignment pipe
package fp_align_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  // Shifts of at least MANT_W + SAT_OFS push the hidden bit past the round position.
  localparam int SAT_OFS = 3;

  // Magnitude of a sign-extended two's-complement value; the most negative input stays exact.
  function automatic logic [31:0] abs_diff(input logic [31:0] d);
    return (d ^ {32{d[31]}}) + {31'b0, d[31]};
  endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// rtl/fp_sticky_shift.sv - log2-stage right barrel shifter collecting shifted-out bits as sticky
module fp_sticky_shift #(
  parameter int W  = 26,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  vec_in,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  vec_out,
  output logic          sticky
);

  logic [W-1:0] stage [SW+1];
  logic         st    [SW+1];

  assign stage[0] = vec_in;
  assign st[0]    = 1'b0;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int SH = 1 << k;
    if (SH >= W) begin : g_all
      assign stage[k+1] = amt[k] ? '0 : stage[k];
      assign st[k+1]    = st[k] | (amt[k] & (|stage[k]));
    end else begin : g_part
      assign stage[k+1] = amt[k] ? (stage[k] >> SH) : stage[k];
      assign st[k+1]    = st[k] | (amt[k] & (|stage[k][SH-1:0]));
    end
  end

  assign vec_out = stage[SW];
  assign sticky  = st[SW];

endmodule

// File: rtl/fp_align_shift_pipe.sv
// rtl/fp_align_shift_pipe.sv - two-stage significand alignment shifter with G/R/S and optional rounding
module fp_align_shift_pipe
  import fp_align_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_hidden,
  input  logic [EXP_W-1:0]  in_diff,
  input  logic              in_round_en,
  input  logic [1:0]        in_rm,
  input  logic              in_sign,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W:0]   out_mant,
  output logic              out_guard,
  output logic              out_round,
  output logic              out_sticky,
  output logic              out_carry,
  output logic              out_inexact,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int SIG_W   = MANT_W + 1;
  localparam int VEC_W   = MANT_W + 3;
  localparam int AMT_W   = EXP_W + 1;
  localparam int SH_W    = $clog2(VEC_W);
  localparam int SAT_AMT = MANT_W + SAT_OFS;

  logic              s1_valid, s2_valid, s1_load, s2_load;
  logic [MANT_W-1:0] s1_mant;
  logic              s1_hidden, s1_round_en, s1_sign;
  logic [AMT_W-1:0]  s1_amt;
  rm_e               s1_rm;
  logic [TAG_W-1:0]  s1_tag;
  logic [AMT_W-1:0]  in_amt;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign in_amt    = AMT_W'(abs_diff(32'(signed'(in_diff))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_mant     <= '0;
      s1_hidden   <= 1'b0;
      s1_amt      <= '0;
      s1_round_en <= 1'b0;
      s1_rm       <= RM_RNE;
      s1_sign     <= 1'b0;
      s1_tag      <= '0;
    end else if (s1_load) begin
      s1_valid    <= in_valid;
      s1_mant     <= in_mant;
      s1_hidden   <= in_hidden;
      s1_amt      <= in_amt;
      s1_round_en <= in_round_en;
      s1_rm       <= rm_e'(in_rm);
      s1_sign     <= in_sign;
      s1_tag      <= in_tag;
    end
  end

  logic [VEC_W-1:0] sh_out;
  logic             sh_sticky;

  fp_sticky_shift #(.W(VEC_W), .SW(SH_W)) u_shift (
    .vec_in  ({s1_hidden, s1_mant, 2'b00}),
    .amt     (s1_amt[SH_W-1:0]),
    .vec_out (sh_out),
    .sticky  (sh_sticky)
  );

  logic             sat, al_g, al_r, al_s, inexact, inc;
  logic [SIG_W-1:0] al_mant;
  logic [SIG_W:0]   sum;

  always_comb begin
    sat     = (s1_amt >= AMT_W'(SAT_AMT));
    al_mant = sat ? '0 : sh_out[VEC_W-1:2];
    al_g    = !sat && sh_out[1];
    al_r    = !sat && sh_out[0];
    al_s    = sat ? (s1_hidden || (|s1_mant)) : sh_sticky;
    inexact = al_g || al_r || al_s;
    inc     = 1'b0;
    case (s1_rm)
      RM_RNE: inc = al_g && (al_r || al_s || al_mant[0]);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = inexact && !s1_sign;
      RM_RDN: inc = inexact && s1_sign;
    endcase
    sum = {1'b0, al_mant} + {{SIG_W{1'b0}}, inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      out_mant    <= '0;
      out_guard   <= 1'b0;
      out_round   <= 1'b0;
      out_sticky  <= 1'b0;
      out_carry   <= 1'b0;
      out_inexact <= 1'b0;
      out_tag     <= '0;
    end else if (s2_load) begin
      s2_valid    <= s1_valid;
      out_tag     <= s1_tag;
      out_inexact <= inexact;
      if (s1_round_en) begin
        out_mant   <= sum[SIG_W-1:0];
        out_carry  <= sum[SIG_W];
        out_guard  <= 1'b0;
        out_round  <= 1'b0;
        out_sticky <= 1'b0;
      end else begin
        out_mant   <= al_mant;
        out_carry  <= 1'b0;
        out_guard  <= al_g;
        out_round  <= al_r;
        out_sticky <= al_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_shift_pipe.sv
// tb/tb_fp_align_shift_pipe.sv - self-checking bench for fp_align_shift_pipe
module tb_fp_align_shift_pipe;

  localparam int MW = 23;
  localparam int EW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_hidden, in_round_en, in_sign;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_diff;
  logic [1:0]    in_rm;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_guard, out_round, out_sticky, out_carry, out_inexact;
  logic [MW:0]   out_mant;
  logic [TW-1:0] out_tag;

  fp_align_shift_pipe #(.MANT_W(MW), .EXP_W(EW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_hidden(in_hidden),
    .in_diff(in_diff), .in_round_en(in_round_en), .in_rm(in_rm), .in_sign(in_sign), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_guard(out_guard),
    .out_round(out_round), .out_sticky(out_sticky), .out_carry(out_carry),
    .out_inexact(out_inexact), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MW:0]   mant;
    logic          g, r, s, c, ix;
    logic [TW-1:0] tag;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   total = 0, bad = 0, cyc = 0, n_out = 0;
  res_t last, held, dut_res;
  logic stalled = 1'b0, chk_lat = 1'b1, rand_rdy = 1'b0;

  assign dut_res = {out_mant, out_guard, out_round, out_sticky, out_carry, out_inexact, out_tag};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: integer arithmetic on the whole significand, no staged shifting.
  function automatic res_t model(input logic h, input logic [MW-1:0] m, input logic [EW-1:0] d,
                                 input logic re, input logic [1:0] rm, input logic sg,
                                 input logic [TW-1:0] tg);
    res_t   e;
    int     amt;
    longint sig, full, kept, mant, sum;
    logic   g, r, s, inc;
    amt = int'($signed(d));
    if (amt < 0) amt = -amt;
    sig = longint'({h, m});
    g = 1'b0; r = 1'b0; s = 1'b0; mant = 0;
    if (amt == 0) mant = sig;
    else if (amt >= MW + 3) s = (sig != 0);
    else begin
      full = sig << 2;
      kept = full >> amt;
      mant = kept >> 2;
      g    = kept[1];
      r    = kept[0];
      s    = (full & ((64'd1 << amt) - 1)) != 0;
    end
    e     = '0;
    e.tag = tg;
    e.ix  = g | r | s;
    if (re) begin
      case (rm)
        2'd0:    inc = g & (r | s | mant[0]);
        2'd2:    inc = (g | r | s) & ~sg;
        2'd3:    inc = (g | r | s) & sg;
        default: inc = 1'b0;
      endcase
      sum    = mant + longint'(inc);
      e.mant = sum[MW:0];
      e.c    = sum[MW+1];
    end else begin
      e.mant = mant[MW:0];
      e.g = g; e.r = r; e.s = s;
    end
    return e;
  endfunction

  function automatic res_t mk(input logic [MW:0] m, input logic g, input logic r, input logic s,
                              input logic c, input logic ix);
    return {m, g, r, s, c, ix, 4'hA};
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: samples one time unit before each rising edge.
  initial forever begin
    @(negedge clk);
    #4;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check("stalled_stable", {31'b0, out_valid, dut_res}, {31'b0, 1'b1, held});
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_hidden, in_mant, in_diff, in_round_en, in_rm, in_sign, in_tag));
        acc_q.push_back(cyc);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'd0);
        else begin
          check("result", 64'(dut_res), 64'(exp_q[0]));
          if (out_ready) begin
            if (chk_lat) check("latency", 64'(cyc - acc_q[0]), 64'd2);
            last = dut_res;
            n_out++;
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = dut_res;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic h, input logic [MW-1:0] m, input logic [EW-1:0] d, input logic re,
                      input logic [1:0] rm, input logic sg, input logic [TW-1:0] tg);
    in_hidden = h; in_mant = m; in_diff = d; in_round_en = re; in_rm = rm; in_sign = sg; in_tag = tg;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #4;
      if (in_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic one(input string name, input logic h, input logic [MW-1:0] m, input logic [EW-1:0] d,
                     input logic re, input logic [1:0] rm, input logic sg, input res_t want);
    int n0;
    n0 = n_out;
    send(h, m, d, re, rm, sg, 4'hA);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && n_out == n0; i++) @(negedge clk);
    check({name, "_done"}, 64'(n_out - n0), 64'd1);
    check(name, 64'(last), 64'(want));
  endtask

  logic [EW-1:0] diffs [16] = '{8'd0, 8'd1, 8'hFF, 8'd5, 8'hF0, 8'd25, 8'd26, 8'h80,
                                8'd2, 8'hFE, 8'd12, 8'd23, 8'd24, 8'h7F, 8'd3, 8'hE7};

  task automatic stream(input int i);
    send(1'b1, MW'($urandom), diffs[i], 1'(i & 1), 2'((i >> 1) & 3), 1'((i >> 3) & 1), TW'(i));
  endtask

  initial begin
    int n_rst;
    in_valid = 1'b0; in_hidden = 1'b0; in_mant = '0; in_diff = '0;
    in_round_en = 1'b0; in_rm = 2'd0; in_sign = 1'b0; in_tag = '0;
    repeat (3) @(negedge clk);
    #4;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_mant", 64'(out_mant), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    one("passthru", 1'b1, 23'h400000, 8'd0, 1'b0, 2'd0, 1'b0, mk(24'hC00000, 0, 0, 0, 0, 0));
    one("grs_all", 1'b1, 23'h000007, 8'hFD, 1'b0, 2'd0, 1'b0, mk(24'h100000, 1, 1, 1, 0, 1));
    // After any nonzero shift the top bit is clear, so the increment lands in bit MANT_W.
    one("rne_up", 1'b1, 23'h7FFFFF, 8'd1, 1'b1, 2'd0, 1'b0, mk(24'h800000, 0, 0, 0, 0, 1));
    one("sat_m128", 1'b0, 23'h000001, 8'h80, 1'b0, 2'd0, 1'b0, mk(24'h0, 0, 0, 1, 0, 1));
    one("sat_30", 1'b0, 23'h000001, 8'd30, 1'b0, 2'd0, 1'b0, mk(24'h0, 0, 0, 1, 0, 1));
    one("sat_zero", 1'b0, 23'h000000, 8'd30, 1'b0, 2'd0, 1'b0, mk(24'h0, 0, 0, 0, 0, 0));
    one("tie_rne", 1'b1, 23'h000001, 8'd1, 1'b1, 2'd0, 1'b0, mk(24'h400000, 0, 0, 0, 0, 1));
    one("tie_rup", 1'b1, 23'h000001, 8'd1, 1'b1, 2'd2, 1'b0, mk(24'h400001, 0, 0, 0, 0, 1));
    one("tie_rdn", 1'b1, 23'h000001, 8'd1, 1'b1, 2'd3, 1'b0, mk(24'h400000, 0, 0, 0, 0, 1));
    one("tie_rtz", 1'b1, 23'h000001, 8'd1, 1'b1, 2'd1, 1'b0, mk(24'h400000, 0, 0, 0, 0, 1));
    one("tie_rdn_neg", 1'b1, 23'h000001, 8'd1, 1'b1, 2'd3, 1'b1, mk(24'h400001, 0, 0, 0, 0, 1));

    chk_lat  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) stream(i);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #4;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    n_rst = n_out;
    for (int i = 8; i < 16; i++) stream(i);
    in_valid = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drained", 64'(exp_q.size()), 64'd0);
    check("post_reset_count", 64'(n_out - n_rst), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
